// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and defaults for the two-requester mux arbiter
package mux_arb_pkg;

    // Requester identity, used for the winner, the last grant and the output source tag.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;

    // Width of the burst counter: must hold 0..max_burst inclusive.
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mux_2x1.sv
// rtl/mux_2x1.sv - 8-bit two-input data mux steered by a requester select
module mux_2x1 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sel_i,
    output logic [7:0] y_o
);

    // sel_i = 0 passes a_i, sel_i = 1 passes b_i.
    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux_2x1_arb.sv
// rtl/mux_2x1_arb.sv - burst-limited round-robin arbiter sharing one mux_2x1 datapath
module mux_2x1_arb
    import mux_arb_pkg::*;
#(
    // The shared mux_2x1 is 8 bits wide, so DATA_W stays at 8 in this revision.
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    output src_e              y_src_o,
    input  logic              y_ready_i
);

    localparam int                CNT_W   = burst_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);

    logic              r_y_valid;
    logic [DATA_W-1:0] r_y_data;
    src_e              r_y_src;
    src_e              r_last_gnt;
    logic [CNT_W-1:0]  r_burst_cnt;

    logic              w_can_accept;
    logic              w_win_vld;
    src_e              w_winner;
    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_xfer;
    logic [DATA_W-1:0] w_mux_y;

    // A new beat may load when the register is empty or is draining this cycle.
    assign w_can_accept = !r_y_valid || y_ready_i;

    // Pick the winner: a lone requester always wins; under contention the last
    // grantee keeps the bus until it has used up its burst allowance.
    always_comb begin
        w_winner  = SRC_A;
        w_win_vld = 1'b0;
        unique case ({a_valid_i, b_valid_i})
            2'b10: begin
                w_winner  = SRC_A;
                w_win_vld = 1'b1;
            end
            2'b01: begin
                w_winner  = SRC_B;
                w_win_vld = 1'b1;
            end
            2'b11: begin
                w_winner  = (r_burst_cnt < MAX_CNT) ? r_last_gnt : src_e'(~r_last_gnt);
                w_win_vld = 1'b1;
            end
            default: begin
                w_winner  = SRC_A;
                w_win_vld = 1'b0;
            end
        endcase
    end

    // Readies depend only on valids, burst state and the output handshake, never on data.
    assign w_a_ready = w_can_accept && a_valid_i && w_win_vld && (w_winner == SRC_A);
    assign w_b_ready = w_can_accept && b_valid_i && w_win_vld && (w_winner == SRC_B);
    assign w_xfer    = w_a_ready || w_b_ready;

    mux_2x1 u_mux (
        .a_i   (a_data_i),
        .b_i   (b_data_i),
        .sel_i (w_winner),
        .y_o   (w_mux_y)
    );

    // Output register, last grant and burst counter; reset discards any held beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_y_valid   <= 1'b0;
            r_y_data    <= '0;
            r_y_src     <= SRC_A;
            r_last_gnt  <= SRC_A;
            r_burst_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_y_valid <= 1'b1;
                r_y_data  <= w_mux_y;
                r_y_src   <= w_winner;
                if (w_winner == r_last_gnt) begin
                    if (r_burst_cnt != MAX_CNT) begin
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                    end
                end else begin
                    r_burst_cnt <= CNT_W'(1);
                    r_last_gnt  <= w_winner;
                end
            end else if (y_ready_i && r_y_valid) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign a_ready_o = w_a_ready;
    assign b_ready_o = w_b_ready;
    assign y_valid_o = r_y_valid;
    assign y_data_o  = r_y_data;
    assign y_src_o   = r_y_src;

endmodule

// File: tb/tb_mux_2x1_arb.sv
// tb/tb_mux_2x1_arb.sv - self-checking bench for mux_2x1_arb at MAX_BURST 4, 2 and 1
module tb_mux_2x1_arb;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       av [N];
    logic       bv [N];
    logic       yr [N];
    logic [7:0] ad [N];
    logic [7:0] bd [N];
    logic       ar [N];
    logic       br [N];
    logic       yv [N];
    logic       ys [N];
    logic [7:0] yd [N];

    int checks = 0;
    int errors = 0;

    // Reference model: grant history and output register contents.
    int         m_last [N];
    int         m_run  [N];
    bit         m_yv   [N];
    logic [7:0] m_yd   [N];
    bit         m_ys   [N];
    bit         acc_a  [N];
    bit         acc_b  [N];
    logic [5:0] gseq   [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mux_2x1_arb #(
            .DATA_W    (8),
            .MAX_BURST ((g == 0) ? 4 : ((g == 1) ? 2 : 1))
        ) u_dut (
            .clk_i     (clk),
            .rst_n_i   (rst_n),
            .a_valid_i (av[g]),
            .a_data_i  (ad[g]),
            .a_ready_o (ar[g]),
            .b_valid_i (bv[g]),
            .b_data_i  (bd[g]),
            .b_ready_o (br[g]),
            .y_valid_o (yv[g]),
            .y_data_o  (yd[g]),
            .y_src_o   (ys[g]),
            .y_ready_i (yr[g])
        );
    end

    function automatic int mb(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h exp %0h", tag, idx, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_last[i] = 0;
            m_run[i]  = 0;
            m_yv[i]   = 0;
            m_yd[i]   = 8'h00;
            m_ys[i]   = 0;
            acc_a[i]  = 0;
            acc_b[i]  = 0;
        end
    endtask

    task automatic set_all(input logic a_v, input logic [7:0] a_d, input logic b_v,
                           input logic [7:0] b_d, input logic y_r);
        for (int i = 0; i < N; i++) begin
            av[i] = a_v;
            ad[i] = a_d;
            bv[i] = b_v;
            bd[i] = b_d;
            yr[i] = y_r;
        end
    endtask

    // Called on a falling edge with inputs already applied; ends on the next falling edge.
    task automatic step();
        #1;
        for (int i = 0; i < N; i++) begin
            int win;
            bit can;
            bit ea;
            bit eb;
            if (av[i] && bv[i])  win = (m_run[i] < mb(i)) ? m_last[i] : 1 - m_last[i];
            else if (av[i])      win = 0;
            else if (bv[i])      win = 1;
            else                 win = -1;
            can = !m_yv[i] || yr[i];
            ea  = can && av[i] && (win == 0);
            eb  = can && bv[i] && (win == 1);
            chk("a_ready", i, ar[i], ea);
            chk("b_ready", i, br[i], eb);
            acc_a[i] = ea;
            acc_b[i] = eb;
            if (ea || eb) begin
                m_yv[i] = 1;
                m_yd[i] = (win == 1) ? bd[i] : ad[i];
                m_ys[i] = (win == 1);
                if (win == m_last[i]) begin
                    if (m_run[i] < mb(i)) m_run[i] = m_run[i] + 1;
                end else begin
                    m_run[i]  = 1;
                    m_last[i] = win;
                end
            end else if (yr[i] && m_yv[i]) begin
                m_yv[i] = 0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("y_valid", i, yv[i], m_yv[i]);
            chk("y_data", i, yd[i], m_yd[i]);
            chk("y_src", i, ys[i], m_ys[i]);
        end
    endtask

    initial begin
        gseq[0] = 6'b110000;
        gseq[1] = 6'b001100;
        gseq[2] = 6'b101010;
        rst_n = 1'b0;
        set_all(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_y_valid", i, yv[i], 1'b0);
            chk("rst_y_data", i, yd[i], 8'h00);
            chk("rst_y_src", i, ys[i], 1'b0);
        end
        rst_n = 1'b1;

        // Continuous contention straight out of reset: per-instance grant patterns.
        set_all(1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            for (int i = 0; i < N; i++) chk("grant_seq", i, ys[i], gseq[i][k]);
        end

        // Single requester A with consecutive beats.
        set_all(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        step();
        chk("single_11", 0, yd[0], 8'h11);
        set_all(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
        step();
        chk("single_22", 0, yd[0], 8'h22);
        set_all(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
        step();
        chk("single_33", 0, yd[0], 8'h33);

        // Idle gap keeps the burst count: MAX_BURST=4 gives A one more, then B.
        set_all(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();
        set_all(1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
        step();
        chk("idle_gap_a", 0, ys[0], 1'b0);
        step();
        chk("idle_gap_b", 0, ys[0], 1'b1);

        // Backpressure: hold 0x5A, then drain and reload in one cycle.
        set_all(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        step();
        set_all(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold", 0, yd[0], 8'h5A);
        end
        set_all(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        step();
        chk("bp_reload", 0, yd[0], 8'h77);
        chk("bp_valid", 0, yv[0], 1'b1);

        // Asynchronous reset mid-operation with a full output register.
        set_all(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("arst_y_valid", i, yv[i], 1'b0);
            chk("arst_y_data", i, yd[i], 8'h00);
            chk("arst_y_src", i, ys[i], 1'b0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_all(1'b1, 8'hC1, 1'b1, 8'hD2, 1'b1);
        step();
        for (int i = 0; i < N; i++) chk("post_rst_grant", i, ys[i], 1'b0);

        // Randomised traffic; requesters hold valid and data until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(av[i] && !acc_a[i])) begin
                    av[i] = ($urandom_range(0, 2) != 0);
                    ad[i] = 8'($urandom);
                end
                if (!(bv[i] && !acc_b[i])) begin
                    bv[i] = ($urandom_range(0, 2) != 0);
                    bd[i] = 8'($urandom);
                end
                yr[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
